ucstats_sched: RTL
==================

# ucstats_sched

Sequences the shared uC stats memory read port among `NUM_LE` link engines once per interval. On each interval tick it grants engines one at a time, in ascending index order, skipping disabled engines. It gives each engine a fixed-length slot, registers and muxes the owner's uC stats address onto the single memory address bus, and reports sweep completion and tick overruns. It sits between the interval-stats timer and the link engines' uC stats read logic and replaces daisy-chained start propagation.

## Interface
Parameters:
- `NUM_LE`, default 4: number of link engines, 1..8.
- `SLOT_CYC`, default 10: cycles per engine slot, including the start cycle; legal range 6..255.
- `IDX_W`, default `$clog2(NUM_LE)` (minimum 1): width of the engine index.

Ports (clock and reset first):
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `iINT_TICK`  in  1  interval tick, one-cycle pulse; requests one sweep.
- `iLE_EN`  in  NUM_LE  per-engine enable mask; sampled at each selection point.
- `iLE_UCSTATS_ADDR`  in  NUM_LE*6  per-engine uC stats address; engine k occupies bits [6k+5:6k].
- `oLE_UC_START`  out  NUM_LE  one-hot start pulse to the granted engine.
- `oUCSTATS_ADDR`  out  6  registered, muxed address to the uC stats memory.
- `oBUSY`  out  1  high while a sweep is in progress (GRANT or WAIT).
- `oSWEEP_DONE`  out  1  one-cycle pulse when a sweep finishes.
- `oOVERRUN_CNT`  out  8  saturating count of ticks dropped.

## Operation
State machine with three states: IDLE, GRANT, WAIT.

IDLE:
- A sweep request is present when `iINT_TICK` is high or `pend_r` is set.
- On a request with any `iLE_EN` bit set:
  - `idx_r` loads the lowest enabled index.
  - `pend_r` clears.
  - Next state is GRANT.
- On a request with `iLE_EN` all zero:
  - `oSWEEP_DONE` pulses next cycle.
  - `pend_r` clears.
  - State stays IDLE.

GRANT (one cycle):
- `oLE_UC_START[idx_r]` is high; all other start bits are low.
- `slot_cnt_r` loads `SLOT_CYC-2`.
- Next state is WAIT.

WAIT:
- While `slot_cnt_r` is nonzero, it decrements by one each cycle.
- When `slot_cnt_r` is 0, the scheduler searches for the lowest enabled index greater than `idx_r`:
  - If one is found, `idx_r` loads it and the next state is GRANT.
  - If none is found, the next state is IDLE and `oSWEEP_DONE` goes high for that first IDLE cycle.

Address mux:
- Each cycle, `oUCSTATS_ADDR` is updated as follows:
  - In GRANT or WAIT: `oUCSTATS_ADDR <= iLE_UCSTATS_ADDR[idx_r]`.
  - In IDLE: `oUCSTATS_ADDR <= 0`.

Tick handling (overrun):
- `iINT_TICK` in GRANT or WAIT, with `pend_r` clear: sets `pend_r`.
- `iINT_TICK` in GRANT or WAIT, with `pend_r` already set: `oOVERRUN_CNT` increments and saturates at 255; `pend_r` stays set.
- A tick on the final WAIT cycle counts as busy and sets `pend_r`. The next sweep then starts from IDLE one cycle after `oSWEEP_DONE`.

Enable changes:
- An enable change takes effect at the next selection point.
- Clearing the enable of the engine currently being served does not cut its slot short.

Reset (asynchronous, including mid-sweep):
- State goes to IDLE.
- `idx_r`, `slot_cnt_r` and `pend_r` go to 0.
- Output reset values:
  - `oLE_UC_START` = 0
  - `oUCSTATS_ADDR` = 0
  - `oBUSY` = 0
  - `oSWEEP_DONE` = 0
  - `oOVERRUN_CNT` = 0

## Timing
- All outputs are registered.
- Tick sampled high at the end of cycle 0 leads to GRANT in cycle 1: `oLE_UC_START` is high in cycle 1 and `oBUSY` is high from cycle 1.
- Slot length is exactly `SLOT_CYC` cycles, so successive grants are `SLOT_CYC` cycles apart.
- Sweep with n enabled engines: `oSWEEP_DONE` is high in cycle 1 + n*SLOT_CYC, and `oBUSY` is low in that same cycle.
- Address latency is one cycle from `iLE_UCSTATS_ADDR` to `oUCSTATS_ADDR`.
- The owner of `oUCSTATS_ADDR` changes on the cycle after the new GRANT. The previous owner's last address (slot cycle `SLOT_CYC-1`) is therefore still forwarded in the new GRANT cycle.
- Engines take the memory data directly. Scheduler latency does not include the memory's 3-cycle data return.

## Test plan
- NUM_LE=4, SLOT_CYC=10, iLE_EN=4'hF, tick at cycle 0 -> expected response:
  - `oLE_UC_START` = 1, 2, 4, 8 at cycles 1, 11, 21, 31.
  - `oSWEEP_DONE` high at cycle 41.
  - `oBUSY` high for cycles 1..40.
- iLE_EN=4'b1010, tick at cycle 0 -> start[1] at cycle 1, start[3] at cycle 11, done at cycle 21.
- iLE_EN=0, tick -> no start pulses; `oSWEEP_DONE` one cycle later; `oBUSY` never high.
- Engine 2 drives address 0x2B during its slot -> `oUCSTATS_ADDR` = 0x2B one cycle later; in IDLE, `oUCSTATS_ADDR` = 0.
- Overrun:
  - Ticks at cycles 5, 15 and 25 during a 4-engine sweep -> `oOVERRUN_CNT` = 2 and one pending sweep.
  - The second sweep's GRANT lands at cycle 42.
  - 300 excess ticks saturate `oOVERRUN_CNT` at 255.
- `rst` asserted at cycle 15 mid-sweep -> all outputs 0 immediately; a tick after release restarts the sweep from engine 0.

Source files
------------

// File: rtl/ucstats_sched.sv
// ucstats_sched
// Shares the uC stats memory read port among NUM_LE link engines. Each interval
// tick starts one sweep. The sweep grants the enabled engines one at a time, in
// ascending index order. Each engine gets a fixed slot of SLOT_CYC cycles. The
// owner's address is registered onto the single memory address bus. Ticks that
// arrive while a sweep is already pending are counted as overruns.
//
// Ports:
//   clk               single clock
//   rst               asynchronous, active-high reset
//   iINT_TICK         interval tick pulse, requests one sweep
//   iLE_EN            per-engine enable mask, sampled at each selection point
//   iLE_UCSTATS_ADDR  per-engine 6-bit address, engine k at [6k+5:6k]
//   oLE_UC_START      one-hot start pulse to the granted engine
//   oUCSTATS_ADDR     registered, muxed address to the uC stats memory
//   oBUSY             high while a sweep is in progress
//   oSWEEP_DONE       one-cycle pulse in the first idle cycle after a sweep
//   oOVERRUN_CNT      saturating count of dropped ticks
module ucstats_sched #(
    parameter int NUM_LE   = 4,
    parameter int SLOT_CYC = 10,
    parameter int IDX_W    = (NUM_LE > 1) ? $clog2(NUM_LE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iINT_TICK,
    input  logic [NUM_LE-1:0]     iLE_EN,
    input  logic [NUM_LE*6-1:0]   iLE_UCSTATS_ADDR,
    output logic [NUM_LE-1:0]     oLE_UC_START,
    output logic [5:0]            oUCSTATS_ADDR,
    output logic                  oBUSY,
    output logic                  oSWEEP_DONE,
    output logic [7:0]            oOVERRUN_CNT
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // The GRANT cycle is the first cycle of the slot, so WAIT counts the rest
    // of the slot down to zero.
    localparam logic [7:0] SLOT_LOAD = 8'(SLOT_CYC - 2);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic [7:0]        slot_cnt_r;
    logic [7:0]        slot_cnt_nxt_s;
    logic              pend_r;
    logic              pend_nxt_s;
    logic [7:0]        ovr_cnt_r;
    logic [7:0]        ovr_cnt_nxt_s;
    logic              done_nxt_s;
    logic [NUM_LE-1:0] start_nxt_s;
    logic [5:0]        addr_nxt_s;
    logic [NUM_LE-1:0] above_s;
    logic [NUM_LE-1:0] start_r;
    logic [5:0]        addr_r;
    logic              busy_r;
    logic              done_r;

    // Mask of engine indices strictly greater than idx.
    function automatic logic [NUM_LE-1:0] above_mask(input logic [IDX_W-1:0] idx);
        logic [NUM_LE-1:0] m;
        m = {NUM_LE{1'b0}};
        for (int k = 0; k < NUM_LE; k++) begin
            m[k] = (k > int'(idx));
        end
        return m;
    endfunction

    // Lowest set index of mask; returns 0 when mask is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_LE-1:0] mask);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int k = NUM_LE - 1; k >= 0; k--) begin
            r = mask[k] ? IDX_W'(k) : r;
        end
        return r;
    endfunction

    // Select the 6-bit address slice of engine idx.
    function automatic logic [5:0] addr_mux(input logic [NUM_LE*6-1:0] addrs,
                                            input logic [IDX_W-1:0]    idx);
        logic [5:0] a;
        a = 6'd0;
        for (int k = 0; k < NUM_LE; k++) begin
            a = (int'(idx) == k) ? addrs[6*k +: 6] : a;
        end
        return a;
    endfunction

    // Next-state, slot counter, pending/overrun and output pre-computation.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        slot_cnt_nxt_s = slot_cnt_r;
        pend_nxt_s     = pend_r;
        ovr_cnt_nxt_s  = ovr_cnt_r;
        done_nxt_s     = 1'b0;
        above_s        = iLE_EN & above_mask(idx_r);

        case (state_r)
            ST_IDLE: begin
                if (iINT_TICK || pend_r) begin
                    pend_nxt_s = 1'b0;
                    if (|iLE_EN) begin
                        idx_nxt_s   = lowest_idx(iLE_EN);
                        state_nxt_s = ST_GRANT;
                    end else begin
                        // Empty sweep: report completion without going busy.
                        done_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                slot_cnt_nxt_s = SLOT_LOAD;
                state_nxt_s    = ST_WAIT;
            end
            ST_WAIT: begin
                if (slot_cnt_r != 8'd0) begin
                    slot_cnt_nxt_s = slot_cnt_r - 8'd1;
                end else if (|above_s) begin
                    idx_nxt_s   = lowest_idx(above_s);
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // A tick while busy is kept as one pending sweep. Any further tick
        // is dropped and counted.
        if (iINT_TICK && (state_r != ST_IDLE)) begin
            if (!pend_r) begin
                pend_nxt_s = 1'b1;
            end else if (ovr_cnt_r != 8'hFF) begin
                ovr_cnt_nxt_s = ovr_cnt_r + 8'd1;
            end else begin
                ovr_cnt_nxt_s = ovr_cnt_r;
            end
        end else begin
            ovr_cnt_nxt_s = ovr_cnt_r;
        end

        // Start is registered, so it is decoded from the state being entered.
        for (int k = 0; k < NUM_LE; k++) begin
            start_nxt_s[k] = (state_nxt_s == ST_GRANT) && (int'(idx_nxt_s) == k);
        end

        if (state_r != ST_IDLE) begin
            addr_nxt_s = addr_mux(iLE_UCSTATS_ADDR, idx_r);
        end else begin
            addr_nxt_s = 6'd0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            slot_cnt_r <= 8'd0;
            pend_r     <= 1'b0;
            ovr_cnt_r  <= 8'd0;
            start_r    <= {NUM_LE{1'b0}};
            addr_r     <= 6'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            slot_cnt_r <= slot_cnt_nxt_s;
            pend_r     <= pend_nxt_s;
            ovr_cnt_r  <= ovr_cnt_nxt_s;
            start_r    <= start_nxt_s;
            addr_r     <= addr_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= done_nxt_s;
        end
    end

    assign oLE_UC_START  = start_r;
    assign oUCSTATS_ADDR = addr_r;
    assign oBUSY         = busy_r;
    assign oSWEEP_DONE   = done_r;
    assign oOVERRUN_CNT  = ovr_cnt_r;

endmodule
